// File: rtl/keypad_pkg.sv
// Shared types, constants and key decode helpers for the keypad digit scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    EMIT       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam logic [1:0] KEY_DIGIT = 2'd0;
  localparam logic [1:0] KEY_CLEAR = 2'd1;
  localparam logic [1:0] KEY_ENTER = 2'd2;
  localparam logic [1:0] KEY_FUNC  = 2'd3;

  localparam logic [3:0] ROW_RESET = 4'b1110;

  typedef struct packed {
    logic [1:0] kind;
    logic [3:0] value;
  } key_info_t;

  // Row/column position to key class and value.
  function automatic key_info_t key_map(input logic [1:0] row, input logic [1:0] col);
    key_info_t k;
    k.kind  = KEY_DIGIT;
    k.value = 4'd0;
    case ({row, col})
      4'd0:  k.value = 4'd1;
      4'd1:  k.value = 4'd2;
      4'd2:  k.value = 4'd3;
      4'd3:  begin k.kind = KEY_FUNC;  k.value = 4'hA; end
      4'd4:  k.value = 4'd4;
      4'd5:  k.value = 4'd5;
      4'd6:  k.value = 4'd6;
      4'd7:  begin k.kind = KEY_FUNC;  k.value = 4'hB; end
      4'd8:  k.value = 4'd7;
      4'd9:  k.value = 4'd8;
      4'd10: k.value = 4'd9;
      4'd11: begin k.kind = KEY_FUNC;  k.value = 4'hC; end
      4'd12: begin k.kind = KEY_CLEAR; k.value = 4'hE; end
      4'd13: k.value = 4'd0;
      4'd14: begin k.kind = KEY_ENTER; k.value = 4'hF; end
      default: begin k.kind = KEY_FUNC; k.value = 4'hD; end
    endcase
    return k;
  endfunction

  // Index of the lowest active-low bit; 3 when none or only bit 3 is low.
  function automatic logic [1:0] lowest_low(input logic [3:0] v_n);
    logic [1:0] idx;
    if (!v_n[0])      idx = 2'd0;
    else if (!v_n[1]) idx = 2'd1;
    else if (!v_n[2]) idx = 2'd2;
    else              idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Double-flop synchroniser for asynchronous inputs, with configurable reset value.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture to resolve metastability.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_digit_scanner.sv
// 4x4 keypad scanner: row drive, column debounce, one strobe per key press.
module keypad_digit_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEBOUNCE_TICKS = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] KEY_COL_N,
  input  logic       Digit_accept,
  output logic [3:0] KEY_ROW_N,
  output logic [3:0] Digit_out,
  output logic       Digit_valid,
  output logic       Clear_pulse,
  output logic       Enter_pulse,
  output logic       Key_busy
);

  localparam int unsigned TICK_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W   = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_DONE   = DB_W'(DEBOUNCE_TICKS);

  logic [3:0]        w_cols;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              w_tick;

  state_e            r_state,    w_state_nxt;
  logic [3:0]        r_row_n,    w_row_nxt;
  logic [1:0]        r_cand_col, w_col_nxt;
  logic [DB_W-1:0]   r_db_cnt,   w_cnt_nxt;
  logic [3:0]        r_digit,    w_digit_nxt;
  logic              r_valid,    w_valid_nxt;
  logic              r_clear,    w_clear_nxt;
  logic              r_enter,    w_enter_nxt;
  logic              r_busy,     w_busy_nxt;

  logic [3:0]        w_row_adv;
  logic [DB_W-1:0]   w_db_inc;
  key_info_t         w_key;

  sync_2ff #(.WIDTH(4), .RESET_VAL(4'hF)) u_col_sync (
    .i_clk (CLK),
    .i_rst (RESET),
    .i_d   (KEY_COL_N),
    .o_q   (w_cols)
  );

  // Free-running scan tick divider.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)       r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + TICK_W'(1);
  end

  assign w_tick    = (r_tick_cnt == TICK_LAST);
  assign w_row_adv = {r_row_n[2:0], r_row_n[3]};
  assign w_db_inc  = r_db_cnt + DB_W'(1);
  assign w_key     = key_map(lowest_low(r_row_n), r_cand_col);

  // State and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= SCAN;
      r_row_n    <= ROW_RESET;
      r_cand_col <= 2'd0;
      r_db_cnt   <= '0;
      r_digit    <= 4'd0;
      r_valid    <= 1'b0;
      r_clear    <= 1'b0;
      r_enter    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_row_n    <= w_row_nxt;
      r_cand_col <= w_col_nxt;
      r_db_cnt   <= w_cnt_nxt;
      r_digit    <= w_digit_nxt;
      r_valid    <= w_valid_nxt;
      r_clear    <= w_clear_nxt;
      r_enter    <= w_enter_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Next-state, row advance, debounce counting and strobe generation.
  always_comb begin
    w_state_nxt = r_state;
    w_row_nxt   = r_row_n;
    w_col_nxt   = r_cand_col;
    w_cnt_nxt   = r_db_cnt;
    w_digit_nxt = r_digit;
    w_valid_nxt = 1'b0;
    w_clear_nxt = 1'b0;
    w_enter_nxt = 1'b0;

    case (r_state)
      SCAN: begin
        if (w_tick) begin
          if (w_cols != 4'hF) begin
            w_col_nxt   = lowest_low(w_cols);
            w_cnt_nxt   = '0;
            w_state_nxt = PRESS_DB;
          end else begin
            w_row_nxt = w_row_adv;
          end
        end
      end
      PRESS_DB: begin
        if (w_tick) begin
          if (!w_cols[r_cand_col]) begin
            w_cnt_nxt = w_db_inc;
            if (w_db_inc == DB_DONE) w_state_nxt = EMIT;
          end else begin
            w_state_nxt = SCAN;
            w_row_nxt   = w_row_adv;
          end
        end
      end
      EMIT: begin
        case (w_key.kind)
          KEY_DIGIT: begin
            if (Digit_accept) begin
              w_valid_nxt = 1'b1;
              w_digit_nxt = w_key.value;
            end
          end
          KEY_CLEAR: w_clear_nxt = 1'b1;
          KEY_ENTER: w_enter_nxt = 1'b1;
          default:   ;
        endcase
        w_cnt_nxt   = '0;
        w_state_nxt = RELEASE_DB;
      end
      RELEASE_DB: begin
        if (w_tick) begin
          if (w_cols == 4'hF) begin
            w_cnt_nxt = w_db_inc;
            if (w_db_inc == DB_DONE) begin
              w_state_nxt = SCAN;
              w_row_nxt   = w_row_adv;
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
      end
      default: w_state_nxt = SCAN;
    endcase

    w_busy_nxt = (w_state_nxt != SCAN);
  end

  assign KEY_ROW_N   = r_row_n;
  assign Digit_out   = r_digit;
  assign Digit_valid = r_valid;
  assign Clear_pulse = r_clear;
  assign Enter_pulse = r_enter;
  assign Key_busy    = r_busy;

endmodule

// File: tb/tb_keypad_digit_scanner.sv
// Self-checking bench for keypad_digit_scanner with a keypad matrix model and strobe scoreboard.
module tb_keypad_digit_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DB_TICKS = 3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] KEY_COL_N;
  logic       Digit_accept = 1'b1;
  logic [3:0] KEY_ROW_N;
  logic [3:0] Digit_out;
  logic       Digit_valid;
  logic       Clear_pulse;
  logic       Enter_pulse;
  logic       Key_busy;

  logic [15:0] keys = '0;

  typedef struct {
    int kind;
    int val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_strobe_cyc = -10;
  int   strobe_cnt = 0;

  keypad_digit_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_TICKS(DB_TICKS)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .KEY_COL_N    (KEY_COL_N),
    .Digit_accept (Digit_accept),
    .KEY_ROW_N    (KEY_ROW_N),
    .Digit_out    (Digit_out),
    .Digit_valid  (Digit_valid),
    .Clear_pulse  (Clear_pulse),
    .Enter_pulse  (Enter_pulse),
    .Key_busy     (Key_busy)
  );

  always #5 CLK = ~CLK;

  // Keypad matrix: a pressed key pulls its column low while its row is driven.
  always_comb begin
    KEY_COL_N = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !KEY_ROW_N[r]) KEY_COL_N[c] = 1'b0;
  end

  // Strobe monitor: pops the scoreboard on every strobe.
  always @(negedge CLK) begin : monitor
    exp_t e;
    int   kind;
    cyc = cyc + 1;
    if (!RESET && (Digit_valid || Clear_pulse || Enter_pulse)) begin
      kind = Digit_valid ? 0 : (Clear_pulse ? 1 : 2);
      vectors++;
      if (($countones({Digit_valid, Clear_pulse, Enter_pulse}) != 1) || (cyc - last_strobe_cyc == 1)) begin
        miscompares++;
        $display("FAIL strobe_shape: got v/c/e=%b%b%b gap=%0d, required single non-consecutive strobe",
                 Digit_valid, Clear_pulse, Enter_pulse, cyc - last_strobe_cyc);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_strobe: got kind=%0d digit=%0d, required no strobe", kind, Digit_out);
      end else begin
        e = exp_q.pop_front();
        if (e.kind != kind || (kind == 0 && Digit_out !== 4'(e.val))) begin
          miscompares++;
          $display("FAIL strobe_value: got kind=%0d digit=%0d, required kind=%0d digit=%0d",
                   kind, Digit_out, e.kind, e.val);
        end
      end
      last_strobe_cyc = cyc;
      strobe_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wait_busy(input logic val, input int budget, input string name);
    int n = 0;
    while (Key_busy !== val && n < budget) begin
      @(negedge CLK);
      n++;
    end
    vectors++;
    if (Key_busy !== val) begin
      miscompares++;
      $display("FAIL %s: Key_busy got %b, required %b within %0d cycles", name, Key_busy, val, budget);
    end
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    wait_cycles(2);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s: %0d expected strobes missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check4(input logic [3:0] got, input logic [3:0] req, input string name);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  task automatic check_int(input int got, input int req, input string name);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check4(KEY_ROW_N, 4'b1110, {name, "_row"});
    check4(Digit_out, 4'd0, {name, "_digit"});
    check4({1'b0, Digit_valid, Clear_pulse, Enter_pulse}, 4'd0, {name, "_strobes"});
    check4({3'd0, Key_busy}, 4'd0, {name, "_busy"});
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    wait_cycles(3);
    check_reset_outputs("reset");
    RESET = 1'b0;
    wait_cycles(SCAN_DIV);
    check4(KEY_ROW_N, 4'b1101, "first_row_advance");
    check4({3'd0, Key_busy}, 4'd0, "idle_busy");
  endtask

  task automatic test_hold_7();
    int s0 = strobe_cnt;
    exp_q.push_back('{0, 7});
    keys[8] = 1'b1;
    wait_cycles(30 * SCAN_DIV);
    check4({3'd0, Key_busy}, 4'd1, "hold7_busy");
    check4(Digit_out, 4'd7, "hold7_digit");
    check_int(strobe_cnt - s0, 1, "hold7_count");
    keys = '0;
    wait_cycles(2 * SCAN_DIV);
    check4({3'd0, Key_busy}, 4'd1, "hold7_release_early");
    wait_busy(1'b0, 30, "hold7_release");
    drain(10, "hold7_drain");
  endtask

  task automatic test_bounce_0();
    int s0 = strobe_cnt;
    int stable;
    wait_busy(1'b0, 100, "bounce_idle");
    exp_q.push_back('{0, 0});
    keys[13] = 1'b1;
    wait_cycles(SCAN_DIV);
    keys[13] = 1'b0;
    wait_cycles(SCAN_DIV);
    keys[13] = 1'b1;
    stable = cyc;
    drain(300, "bounce_drain");
    check_int(strobe_cnt - s0, 1, "bounce_count");
    vectors++;
    if (last_strobe_cyc - stable < int'(DB_TICKS * SCAN_DIV)) begin
      miscompares++;
      $display("FAIL bounce_latency: got %0d cycles after stable, required >= %0d",
               last_strobe_cyc - stable, DB_TICKS * SCAN_DIV);
    end
    check4(Digit_out, 4'd0, "bounce_digit");
    keys = '0;
    wait_busy(1'b0, 100, "bounce_release");
  endtask

  task automatic test_simultaneous();
    exp_q.push_back('{0, 1});
    keys[0] = 1'b1;
    keys[2] = 1'b1;
    drain(300, "simul_drain");
    check4(Digit_out, 4'd1, "simul_digit");
    keys = '0;
    wait_busy(1'b0, 100, "simul_release");
  endtask

  task automatic test_accept_off();
    Digit_accept = 1'b0;
    keys[5] = 1'b1;
    wait_busy(1'b1, 200, "noacc_press");
    wait_cycles(8 * SCAN_DIV);
    check4({3'd0, Key_busy}, 4'd1, "noacc_held");
    check4(Digit_out, 4'd1, "noacc_digit_hold");
    keys = '0;
    wait_busy(1'b0, 100, "noacc_release");
    exp_q.push_back('{2, 0});
    keys[14] = 1'b1;
    drain(300, "enter_drain");
    check4(Digit_out, 4'd1, "enter_digit_hold");
    keys = '0;
    wait_busy(1'b0, 100, "enter_release");
    Digit_accept = 1'b1;
  endtask

  task automatic test_star_hold();
    int s0 = strobe_cnt;
    exp_q.push_back('{1, 0});
    keys[12] = 1'b1;
    drain(300, "star_drain");
    for (int i = 0; i < 5; i++) begin
      wait_cycles(4 * SCAN_DIV);
      check4(KEY_ROW_N, 4'b0111, "star_row_held");
    end
    check_int(strobe_cnt - s0, 1, "star_count");
    keys = '0;
    wait_busy(1'b0, 100, "star_release");
  endtask

  task automatic test_reset_mid();
    int s0;
    int rel;
    keys[10] = 1'b1;
    wait_busy(1'b1, 200, "rst9_press");
    wait_cycles(SCAN_DIV);
    RESET = 1'b1;
    #1;
    check_reset_outputs("rst9_async");
    wait_cycles(3);
    s0 = strobe_cnt;
    RESET = 1'b0;
    rel = cyc;
    exp_q.push_back('{0, 9});
    drain(400, "rst9_drain");
    check_int(strobe_cnt - s0, 1, "rst9_count");
    check4(Digit_out, 4'd9, "rst9_digit");
    vectors++;
    if (last_strobe_cyc - rel < int'((2 + DB_TICKS) * SCAN_DIV)) begin
      miscompares++;
      $display("FAIL rst9_latency: got %0d cycles after reset release, required >= %0d",
               last_strobe_cyc - rel, (2 + DB_TICKS) * SCAN_DIV);
    end
    keys = '0;
    wait_busy(1'b0, 100, "rst9_release");
  endtask

  initial begin
    test_reset();
    test_hold_7();
    test_bounce_0();
    test_simultaneous();
    test_accept_off();
    test_star_hold();
    test_reset_mid();
    wait_cycles(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/keypad_digit_scanner.md
Name: keypad_digit_scanner

Overview:
- 4x4 matrix keypad scanner that produces the digit stream for the barcode entry path.
- Drives keypad rows, synchronises and debounces the columns, and decodes one key per press.
- Emits a one-cycle Digit_valid strobe with Digit_out, intended to feed the barcode shift register's ENABLE/Digit_in inputs.
- Also emits Clear/Enter strobes for '*' and '#'.

Parameters:
- SCAN_DIV, 50000: clock cycles per scan tick (1 ms at 50 MHz); legal range >= 2.
- DEBOUNCE_TICKS, 8: consecutive agreeing tick samples required for a press or release; legal range >= 1.

Ports:
- CLK  input  1  system clock (CLOCK_50).
- RESET  input  1  asynchronous, active-high reset.
- KEY_COL_N  input  4  keypad columns, active-low, pulled up, asynchronous to CLK.
- Digit_accept  input  1  1 = digit keys may be emitted; 0 = digit presses are dropped (e.g. barcode register full).
- KEY_ROW_N  output  4  row drive, one-hot active-low.
- Digit_out  output  4  BCD value of the last emitted digit.
- Digit_valid  output  1  one-cycle strobe: Digit_out is new.
- Clear_pulse  output  1  one-cycle strobe on '*'.
- Enter_pulse  output  1  one-cycle strobe on '#'.
- Key_busy  output  1  high whenever the FSM is not in SCAN.

Behaviour:
- Interface: one clock, CLK; reset RESET is asynchronous and active-high.
- Reset values:
  - KEY_ROW_N = 4'b1110 (row 0 driven).
  - Digit_out = 0; Digit_valid, Clear_pulse, Enter_pulse and Key_busy = 0.
  - FSM = SCAN; tick counter and debounce counter = 0; synchroniser flops = 4'hF.
- Reset asserted mid-operation aborts everything; no strobe is emitted on or after reset release until a complete new press.
- KEY_COL_N passes through a 2-FF synchroniser, giving 2 cycles of latency. All decisions use the synchronised value.
- Tick counter:
  - Free-running, counts 0..SCAN_DIV-1 and wraps.
  - tick = 1 for one cycle when the count equals SCAN_DIV-1.
- Key map (row, col):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: * 0 # D
  - A–D are decoded but produce no strobe; they still go through the release wait.
- FSM states: SCAN, PRESS_DB, EMIT, RELEASE_DB.
- SCAN:
  - On a tick with sync cols != 4'hF: latch the current row and the lowest-index low column as the candidate; clear the debounce count; go to PRESS_DB. The row is held.
  - On a tick with all columns high: advance the row (r3 wraps to r0).
  - Only one row changes per tick.
- PRESS_DB (evaluated on ticks only):
  - Candidate column low: count+1; when count reaches DEBOUNCE_TICKS, go to EMIT.
  - Candidate column high: return to SCAN, advance the row, emit nothing.
  - Other columns going low is ignored, so the lowest-index key wins on simultaneous presses.
- EMIT (exactly one cycle, no tick dependence):
  - Digit key and Digit_accept = 1 in this cycle: Digit_valid = 1 and Digit_out = the key value, both registered and visible the cycle after EMIT.
  - Digit key and Digit_accept = 0: no strobe; Digit_out is unchanged.
  - '*' gives Clear_pulse = 1 and '#' gives Enter_pulse = 1, regardless of Digit_accept.
  - At most one strobe per press. Next state is RELEASE_DB with count = 0.
- RELEASE_DB (ticks only, row still held):
  - All sync cols high: count+1.
  - Any column low: count = 0.
  - When count reaches DEBOUNCE_TICKS: go to SCAN and advance the row.
  - A held key never re-emits.
- Digit_out holds its value until the next accepted digit.
- Strobes are never asserted on consecutive cycles.
- Worst-case press-to-strobe latency: 2 sync cycles + (4 + DEBOUNCE_TICKS) ticks + 2 cycles.

Decomposition:
- Shared package keypad_pkg holds:
  - FSM state enum (SCAN, PRESS_DB, EMIT, RELEASE_DB).
  - Key-class constants: KEY_DIGIT, KEY_CLEAR, KEY_ENTER, KEY_FUNC.
  - The 16-entry row/col to {class, value} map as a constant function.
  - Reset row pattern ROW_RESET = 4'b1110.
- One sub-module, sync_2ff: parameterised-width double-flop synchroniser, instantiated for KEY_COL_N.

Test Plan (bench uses SCAN_DIV=4, DEBOUNCE_TICKS=3):
- Hold key '7' (col0 low only while KEY_ROW_N = 4'b1011) for 30 ticks, then release -> exactly one Digit_valid, Digit_out = 4'd7; Key_busy returns to 0 after 3 clean release ticks.
- Press '0' with 1-tick bounce (low, high, low...) during the first 2 ticks, then stable -> no strobe for the bounced attempt; a single strobe with Digit_out = 0 after a stable 3-tick window.
- Digit_accept = 0, press '5', then press '#' -> no Digit_valid and Digit_out keeps its prior value; one Enter_pulse.
- Press '1' and '3' simultaneously (row0, col0+col2 low) -> single strobe, Digit_out = 4'd1.
- Hold '*' indefinitely -> exactly one Clear_pulse; KEY_ROW_N stays 4'b0111; no further strobes.
- Assert RESET during PRESS_DB of '9', release RESET with the key still held -> outputs at reset values immediately (asynchronous); one Digit_valid = 9 after a fresh full debounce, none before.
